// File: rtl/borrow_serial_subtractor_64bit_if.sv
// Operand/result handshake bundle for the serial subtractor.
// The issue side drives operands and the writeback side drives out_ready.
interface borrow_serial_subtractor_64bit_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             zero;
  logic             negative;
  logic             overflow;

  modport master (
    output in_valid, a, b, borrow_in,
    output abort, out_ready,
    input  in_ready, out_valid, diff,
    input  borrow_out, zero, negative,
    input  overflow
  );

  modport slave (
    input  in_valid, a, b, borrow_in,
    input  abort, out_ready,
    output in_ready, out_valid, diff,
    output borrow_out, zero, negative,
    output overflow
  );
endinterface

// File: rtl/borrow_serial_subtractor_64bit.sv
// Digit-serial a - b - borrow_in, one CHUNK-bit digit per cycle, LSD first.
// Flags are registered on the final digit for compare/branch resolution.
module borrow_serial_subtractor_64bit #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 4
) (
  input  logic clk,
  input  logic reset,
  borrow_serial_subtractor_64bit_if.slave io
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             bw_q, bw_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_out_q, borrow_out_d;
  logic             zero_q, zero_d;
  logic             negative_q, negative_d;
  logic             overflow_q, overflow_d;

  logic [CHUNK-1:0] a_dig;
  logic [CHUNK-1:0] b_dig;
  logic [CHUNK:0]   sub;
  logic [WIDTH-1:0] diff_w;
  logic             last;

  always_comb begin
    a_dig  = CHUNK'(a_q >> (int'(cnt_q) * CHUNK));
    b_dig  = CHUNK'(b_q >> (int'(cnt_q) * CHUNK));
    sub    = {1'b0, a_dig} - {1'b0, b_dig}
           - {{CHUNK{1'b0}}, bw_q};
    diff_w = diff_q;
    diff_w[int'(cnt_q) * CHUNK +: CHUNK] = sub[CHUNK-1:0];
    last   = (cnt_q == CW'(N - 1));
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    bw_d         = bw_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    zero_d       = zero_q;
    negative_d   = negative_q;
    overflow_d   = overflow_q;
    unique case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          a_d     = io.a;
          b_d     = io.b;
          bw_d    = io.borrow_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (io.abort) begin
          state_d = IDLE;
        end else begin
          diff_d = diff_w;
          bw_d   = sub[CHUNK];
          cnt_d  = cnt_q + 1'b1;
          if (last) begin
            // Flags come from the completed word including this digit.
            state_d      = DONE;
            borrow_out_d = sub[CHUNK];
            zero_d       = (diff_w == '0);
            negative_d   = diff_w[WIDTH-1];
            overflow_d   = (a_q[WIDTH-1] != b_q[WIDTH-1])
                         && (diff_w[WIDTH-1] != a_q[WIDTH-1]);
          end
        end
      end
      DONE: begin
        if (io.abort || io.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      bw_q         <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      zero_q       <= 1'b0;
      negative_q   <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      bw_q         <= bw_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
      zero_q       <= zero_d;
      negative_q   <= negative_d;
      overflow_q   <= overflow_d;
    end
  end

  assign io.in_ready   = (state_q == IDLE);
  assign io.out_valid  = (state_q == DONE);
  assign io.diff       = diff_q;
  assign io.borrow_out = borrow_out_q;
  assign io.zero       = zero_q;
  assign io.negative   = negative_q;
  assign io.overflow   = overflow_q;
endmodule

// File: tb/tb_borrow_serial_subtractor_64bit.sv
// Directed-vector bench for the serial subtractor, plus
// backpressure, async reset and abort sequences.
module tb_borrow_serial_subtractor_64bit;
  logic clk;
  logic reset;

  borrow_serial_subtractor_64bit_if #(.WIDTH(64)) io ();

  borrow_serial_subtractor_64bit #(
    .WIDTH(64),
    .CHUNK(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .io   (io.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        bin;
    logic [63:0] d;
    logic        bo;
    logic        z;
    logic        n;
    logic        ov;
  } vec_t;

  int vectors = 0;
  int errs    = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [63:0] a,
                       input logic [63:0] b,
                       input logic bin);
    @(negedge clk);
    io.a         = a;
    io.b         = b;
    io.borrow_in = bin;
    io.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    io.a        = '1;
    io.b        = '1;
  endtask

  task automatic wait_done(output int edges, output bit rdy_seen);
    edges    = 0;
    rdy_seen = 0;
    while (!io.out_valid && edges < 64) begin
      @(posedge clk);
      #1;
      edges++;
      if (io.in_ready) rdy_seen = 1;
    end
  endtask

  task automatic check_res(input vec_t v, input string tag);
    chk({tag, " diff"}, io.diff, v.d);
    chk({tag, " borrow_out"}, 64'(io.borrow_out), 64'(v.bo));
    chk({tag, " zero"}, 64'(io.zero), 64'(v.z));
    chk({tag, " negative"}, 64'(io.negative), 64'(v.n));
    chk({tag, " overflow"}, 64'(io.overflow), 64'(v.ov));
  endtask

  task automatic release_out;
    @(negedge clk);
    io.out_ready = 1'b1;
    @(posedge clk);
    #1;
    io.out_ready = 1'b0;
    chk("idle after out_ready", 64'(io.in_ready), 64'd1);
  endtask

  vec_t vt[9];

  initial begin
    int   e;
    bit   r;
    vec_t bp;
    logic [63:0] hd;

    vt[0] = '{64'h10, 64'h1, 1'b0, 64'hF, 0, 0, 0, 0};
    vt[1] = '{64'h0, 64'h1, 1'b0, '1, 1, 0, 1, 0};
    vt[2] = '{64'h8000_0000_0000_0000, 64'h1, 1'b0,
              64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 0, 1};
    vt[3] = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0,
              1'b0, 64'h0, 0, 1, 0, 0};
    vt[4] = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0,
              1'b1, '1, 1, 0, 1, 0};
    vt[5] = '{64'h5, 64'h3, 1'b0, 64'h2, 0, 0, 0, 0};
    vt[6] = '{'1, '1, 1'b1, '1, 1, 0, 1, 0};
    vt[7] = '{64'h7FFF_FFFF_FFFF_FFFF, '1, 1'b0,
              64'h8000_0000_0000_0000, 1, 0, 1, 1};
    vt[8] = '{64'h0123_4567_89AB_CDEF, 64'h0FED, 1'b0,
              64'h0123_4567_89AB_BE02, 0, 0, 0, 0};

    io.in_valid  = 1'b0;
    io.a         = '0;
    io.b         = '0;
    io.borrow_in = 1'b0;
    io.abort     = 1'b0;
    io.out_ready = 1'b0;
    reset        = 1'b0;
    #1;
    chk("reset in_ready", 64'(io.in_ready), 64'd1);
    chk("reset out_valid", 64'(io.out_valid), 64'd0);
    chk("reset diff", io.diff, 64'd0);
    chk("reset flags",
        64'({io.borrow_out, io.zero, io.negative, io.overflow}), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vt[i]) begin
      vectors++;
      issue(vt[i].a, vt[i].b, vt[i].bin);
      chk("in_ready after accept", 64'(io.in_ready), 64'd0);
      wait_done(e, r);
      chk("latency", 64'(e), 64'd16);
      chk("in_ready during run", 64'(r), 64'd0);
      check_res(vt[i], $sformatf("vec%0d", i));
      release_out();
    end

    // Backpressure with new operands already waiting.
    vectors++;
    issue(64'h10, 64'h1, 1'b0);
    wait_done(e, r);
    chk("bp latency", 64'(e), 64'd16);
    hd = io.diff;
    @(negedge clk);
    io.a        = 64'd100;
    io.b        = 64'd1;
    io.borrow_in = 1'b0;
    io.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("bp out_valid", 64'(io.out_valid), 64'd1);
      chk("bp in_ready", 64'(io.in_ready), 64'd0);
      chk("bp diff", io.diff, hd);
      check_res(vt[0], "bp hold");
    end
    @(negedge clk);
    io.out_ready = 1'b1;
    @(posedge clk);
    #1;
    io.out_ready = 1'b0;
    chk("bp idle", 64'(io.in_ready), 64'd1);
    chk("bp out_valid drop", 64'(io.out_valid), 64'd0);
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    chk("bp accepted", 64'(io.in_ready), 64'd0);
    vectors++;
    wait_done(e, r);
    chk("bp2 latency", 64'(e), 64'd16);
    bp = '{64'd100, 64'd1, 1'b0, 64'd99, 0, 0, 0, 0};
    check_res(bp, "bp2");
    release_out();

    // Asynchronous reset in the middle of RUN.
    vectors++;
    issue('1, 64'h0, 1'b1);
    repeat (7) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("mid reset in_ready", 64'(io.in_ready), 64'd1);
    chk("mid reset out_valid", 64'(io.out_valid), 64'd0);
    chk("mid reset diff", io.diff, 64'd0);
    chk("mid reset flags",
        64'({io.borrow_out, io.zero, io.negative, io.overflow}), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    vectors++;
    issue(vt[5].a, vt[5].b, vt[5].bin);
    wait_done(e, r);
    chk("post reset latency", 64'(e), 64'd16);
    check_res(vt[5], "post reset");
    release_out();

    // Abort during RUN step 3.
    vectors++;
    issue(64'h10, 64'h1, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    io.abort = 1'b1;
    @(posedge clk);
    #1;
    io.abort = 1'b0;
    chk("abort idle", 64'(io.in_ready), 64'd1);
    r = 0;
    for (int c = 0; c < 24; c++) begin
      @(posedge clk);
      #1;
      if (io.out_valid) r = 1;
    end
    chk("abort no result", 64'(r), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/borrow_serial_subtractor_64bit.md
Name: borrow_serial_subtractor_64bit

Overview:
Multi-cycle 64-bit subtract unit for the EX stage. It computes a - b - borrow_in one CHUNK-bit digit per cycle, least significant digit first. It is the subtracting counterpart to the team's 64-bit lookahead adder. A valid/ready handshake on both sides lets the issue logic stall it and lets writeback apply backpressure. It returns the difference plus borrow/zero/negative/overflow flags for compare and branch resolution.

Parameters:
WIDTH, 64, operand and result width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits processed per RUN cycle; must be a divisor of WIDTH, range 1..WIDTH.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low reset.
in_valid  input  1  operands presented.
in_ready  output  1  unit can accept operands.
a  input  WIDTH  minuend.
b  input  WIDTH  subtrahend.
borrow_in  input  1  incoming borrow, subtracted at bit 0.
abort  input  1  synchronous cancel of the in-flight operation.
out_valid  output  1  result and flags valid.
out_ready  input  1  consumer accepts the result.
diff  output  WIDTH  a - b - borrow_in, modulo 2^WIDTH.
borrow_out  output  1  1 when unsigned a < b + borrow_in.
zero  output  1  1 when diff == 0.
negative  output  1  diff[WIDTH-1].
overflow  output  1  signed overflow: a[MSB] != b[MSB] and diff[MSB] != a[MSB].

Behaviour:
- N = WIDTH/CHUNK digit steps. Counter width is clog2(N), minimum 1.
- States are IDLE, RUN and DONE.
- in_ready = (state == IDLE). It is decoded combinationally from the state.
- out_valid = (state == DONE). It is decoded combinationally from the state.
- Reset (reset low, asynchronous):
  - state goes to IDLE; counter, operand registers and partial borrow clear to 0.
  - diff, borrow_out, zero, negative and overflow all read 0.
  - in_ready reads 1 and out_valid reads 0.
- IDLE:
  - On a rising edge with in_valid=1, the unit latches a, b and borrow_in, clears the counter and moves to RUN.
  - in_valid=0 keeps it in IDLE.
  - abort is ignored in IDLE.
- RUN, each edge with counter k:
  - Computes digit k: {bw, d} = a[k*CHUNK +: CHUNK] - b[k*CHUNK +: CHUNK] - borrow, in CHUNK+1 bit arithmetic.
  - Writes d into diff_reg[k*CHUNK +: CHUNK] and keeps bw as the borrow for the next digit.
  - Increments k.
- End of RUN: on the edge where k == N-1, the final digit is written and the unit moves to DONE. The same edge registers the flags:
  - borrow_out = final bw;
  - zero = (complete diff == 0), including the digit being written;
  - negative = complete diff MSB;
  - overflow = signed overflow formula above, using latched a and b.
- Latency: out_valid rises exactly N edges after the accepting edge. With defaults that is 16 cycles. Throughput is one operation per N+2 cycles minimum.
- Outputs:
  - diff and the flags are exposed from registers.
  - They are not meaningful while out_valid=0.
  - During RUN, diff shows the partial result.
- DONE:
  - diff and all flags hold stable.
  - out_ready=1 on an edge moves the unit to IDLE. diff and flags retain their values until the next operation writes them.
  - out_ready=0 holds DONE indefinitely; in_ready stays 0 and in_valid is ignored.
- abort:
  - abort=1 in RUN or DONE on an edge sends the unit to IDLE and drops out_valid. No result is delivered.
  - abort has priority over out_ready and over digit completion.
- Simultaneous events: in DONE, out_ready and in_valid on the same edge do not accept new operands. in_ready is 0 in DONE, so acceptance waits for IDLE.
- Reset mid-operation: reset low in any state clears everything immediately, without waiting for a clock edge. After reset is released the unit accepts the next operands normally, and no stale borrow or partial diff carries over.
- Operands on a and b may change freely after the accepting edge.

Test Plan:
1. Basic subtract: a=0x10, b=0x1, borrow_in=0 -> diff=0xF; borrow_out=0, zero=0, negative=0, overflow=0. out_valid rises 16 edges after acceptance and in_ready is 0 throughout.
2. Negative result: a=0, b=1 -> diff=0xFFFF_FFFF_FFFF_FFFF; borrow_out=1, negative=1, overflow=0, zero=0.
3. Signed overflow: a=0x8000_0000_0000_0000, b=1 -> diff=0x7FFF_FFFF_FFFF_FFFF; overflow=1, negative=0, borrow_out=0.
4. Equal operands: a=b=0x1234_5678_9ABC_DEF0:
   - with borrow_in=0 -> diff=0, zero=1, borrow_out=0;
   - repeated with borrow_in=1 -> diff=all ones, borrow_out=1, zero=0.
5. Backpressure: hold out_ready=0 for 5 cycles after out_valid rises, while driving in_valid=1 with new operands.
   - diff, flags and out_valid stay stable;
   - in_ready stays 0;
   - after out_ready=1 the unit is IDLE and the new operands are accepted the following edge, producing the correct result.
6. Reset and abort:
   - Drive reset low asynchronously at RUN step 7 (mid-cycle) -> all outputs read 0 and in_ready reads 1 immediately. After release, a=5, b=3 gives diff=2.
   - Separately, abort=1 at RUN step 3 -> IDLE next edge and out_valid never asserts for that operation.
